// File: rtl/rr_arb4_pkg.sv
// Shared types and constants for the four-way round-robin arbiter.
// Latency: n/a (declarations and a pure combinational helper only).
// Backpressure: n/a.
package rr_arb4_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // First set request at or above ptr, wrapping 3->0; returns ptr when none is set.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] idx;
        logic             found;
        pick  = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ptr + IDX_W'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/dec24.sv
// 2:4 decoder with enable; drives one output line per select value.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module dec24 (
    input  logic       en,
    input  logic [1:0] a,
    output logic [3:0] d
);

    // One-hot decode of a, or all-zero when disabled.
    always_comb begin
        d = 4'b0000;
        if (en) begin
            d[a] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arb4.sv
// Round-robin arbiter for four requesters with a programmable hold limit.
// Latency: grant one cycle after a request is sampled in IDLE; one bubble after each grant.
// Backpressure: en low blocks new grants only; a winner holds until release or MAX_HOLD cycles.
module rr_arb4
    import rr_arb4_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_id,
    output logic             gnt_valid,
    output logic             expire
);

    // Last cycle count a grant may reach before it is force-ended.
    localparam logic [7:0] CNT_LAST = 8'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] id_d;
    logic             expire_d;
    logic [IDX_W-1:0] win;

    assign win       = rr_pick(req, ptr_q);
    assign gnt_valid = (state_q == GRANT);

    // Next-state logic: pick a winner in IDLE, hold/release/timeout in GRANT.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        id_d     = gnt_id;
        expire_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && (req != '0)) begin
                    state_d = GRANT;
                    id_d    = win;
                    ptr_d   = win + IDX_W'(1);
                    cnt_d   = 8'd0;
                end
            end
            GRANT: begin
                // Release takes precedence over timeout, so expire only fires while still requested.
                if (!req[gnt_id]) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = IDLE;
                    expire_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, rotation pointer, hold counter, winner index and expire pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= 8'd0;
            gnt_id  <= '0;
            expire  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_id  <= id_d;
            expire  <= expire_d;
        end
    end

    // Resource select: decode of registered state, so it is glitch-free and drops with async reset.
    dec24 u_dec24 (
        .en (gnt_valid),
        .a  (gnt_id),
        .d  (gnt)
    );

endmodule

// File: tb/tb_rr_arb4.sv
// Self-checking bench for rr_arb4: directed scenarios plus randomized traffic vs a reference model.
// Latency: inputs applied on the falling edge, outputs compared on the following falling edge.
// Backpressure: n/a.
module tb_rr_arb4;

    localparam int HOLD = 4;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       expire;

    int checks;
    int errors;

    // Reference model: who owns the resource, for how many cycles, and whose turn is next.
    int m_owner;   // -1 when nobody owns it
    int m_last;    // last winner, shown on gnt_id
    int m_turn;    // first requester to consider at the next arbitration
    int m_held;    // cycles the current owner has held so far (1 on first cycle)
    bit m_exp;

    rr_arb4 #(.MAX_HOLD(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .expire    (expire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_gnt();
        logic [3:0] g;
        g = 4'b0000;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 0;
        m_turn  = 0;
        m_held  = 0;
        m_exp   = 1'b0;
    endtask

    // One clock of the specified behaviour, given the inputs seen at that edge.
    task automatic model_clock(input bit e, input logic [3:0] r);
        int w;
        m_exp = 1'b0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_owner = -1;
            end else if (m_held >= HOLD) begin
                m_owner = -1;
                m_exp   = 1'b1;
            end else begin
                m_held++;
            end
        end else if (e && (r != 4'b0000)) begin
            w = -1;
            for (int k = 0; k < 4; k++) begin
                if (w < 0 && r[(m_turn + k) % 4]) w = (m_turn + k) % 4;
            end
            m_owner = w;
            m_last  = w;
            m_turn  = (w + 1) % 4;
            m_held  = 1;
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".gnt"},       32'(gnt),       32'(model_gnt()));
        check({tag, ".gnt_id"},    32'(gnt_id),    32'(m_last));
        check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(m_owner >= 0));
        check({tag, ".expire"},    32'(expire),    32'(m_exp));
    endtask

    // Apply inputs now (falling edge), clock once, then compare on the next falling edge.
    task automatic step(input bit e, input logic [3:0] r, input string tag);
        en  = e;
        req = r;
        @(posedge clk);
        model_clock(e, r);
        @(negedge clk);
        compare_model(tag);
    endtask

    task automatic do_reset();
        en  = 1'b0;
        req = 4'b0000;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst.gnt",       32'(gnt),       32'h0);
        check("rst.gnt_id",    32'(gnt_id),    32'h0);
        check("rst.gnt_valid", 32'(gnt_valid), 32'h0);
        check("rst.expire",    32'(expire),    32'h0);
    endtask

    initial begin
        logic [3:0] exp_g;
        logic [3:0] rq;
        logic [3:0] tseq [6];
        logic       xseq [6];
        bit         e;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        en  = 1'b0;
        req = 4'b0000;
        model_reset();

        // Reset and basic grant.
        do_reset();
        step(1'b1, 4'b0100, "basic");
        check("basic.gnt_const", 32'(gnt), 32'h4);
        check("basic.id_const",  32'(gnt_id), 32'h2);
        step(1'b1, 4'b0000, "basic_rel");
        check("basic_rel.gnt_const", 32'(gnt), 32'h0);

        // Rotation: each winner holds two cycles then drops for one.
        do_reset();
        for (int w = 0; w < 5; w++) begin
            exp_g = 4'b0000;
            exp_g[w % 4] = 1'b1;
            step(1'b1, 4'b1111, "rot");
            check("rot.first", 32'(gnt), 32'(exp_g));
            step(1'b1, 4'b1111, "rot");
            check("rot.second", 32'(gnt), 32'(exp_g));
            if (w < 4) begin
                rq = 4'b1111;
                rq[w] = 1'b0;
                step(1'b1, rq, "rot_rel");
                check("rot.bubble", 32'(gnt), 32'h0);
            end
        end

        // Timeout with the hold limit of 4.
        do_reset();
        tseq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010};
        xseq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 4'b0011, "tmo");
            check("tmo.gnt_const", 32'(gnt), 32'(tseq[i]));
            check("tmo.exp_const", 32'(expire), 32'(xseq[i]));
        end

        // Enable gating new grants but not active ones.
        do_reset();
        step(1'b0, 4'b1000, "en_off");
        check("en_off.gnt_const", 32'(gnt), 32'h0);
        step(1'b0, 4'b1000, "en_off");
        step(1'b1, 4'b1000, "en_on");
        check("en_on.gnt_const", 32'(gnt), 32'h8);
        step(1'b0, 4'b1000, "en_drop");
        check("en_drop.gnt_const", 32'(gnt), 32'h8);
        step(1'b0, 4'b1000, "en_drop");
        step(1'b0, 4'b0000, "en_rel");
        check("en_rel.gnt_const", 32'(gnt), 32'h0);

        // Reset asserted between edges during a grant.
        do_reset();
        step(1'b1, 4'b1000, "mid_a");
        step(1'b1, 4'b0000, "mid_b");
        step(1'b1, 4'b0010, "mid_c");
        check("mid.pre_gnt", 32'(gnt), 32'h2);
        #2;
        rst = 1'b1;
        #1;
        check("mid.async_gnt",   32'(gnt),       32'h0);
        check("mid.async_valid", 32'(gnt_valid), 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 4'b1111, "mid_after");
        check("mid.after_gnt", 32'(gnt), 32'h1);

        // Randomized traffic: requests change occasionally so holds can reach the limit.
        do_reset();
        rq = 4'($urandom_range(0, 15));
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            e = ($urandom_range(0, 4) != 0);
            step(e, rq, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
